// File: rtl/ps2_mouse_packer.sv
// Packs the 3-byte PS/2 mouse stream into the 25-bit SNES mouse word.
// Drops partial packets on bad headers, receiver errors and inter-byte timeouts.
module ps2_mouse_packer #(
  parameter logic [15:0] TIMEOUT = 16'd43000
) (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic [7:0]  rx_data_i,
  input  logic        rx_valid_i,
  input  logic        rx_err_i,
  output logic [24:0] mouse_o,
  output logic        pkt_err_o
);

  // state | meaning
  // S_HDR | waiting for header byte (bit3 must be 1)
  // S_DX  | header held, waiting for X movement byte
  // S_DY  | header and X held, waiting for Y movement byte
  typedef enum logic [1:0] {S_HDR, S_DX, S_DY} state_t;

  state_t      state_q, state_d;
  logic [7:0]  hdr_q, hdr_d;
  logic [7:0]  dx_q, dx_d;
  logic [15:0] cnt_q, cnt_d;
  logic [24:0] mouse_q, mouse_d;
  logic        pkt_err_q, pkt_err_d;
  logic [7:0]  x_sat, y_sat;
  logic        tmo_hit;

  // Overflowed axes saturate; the sign-to-fill mapping is fixed by the SNES side.
  assign x_sat   = hdr_q[6] ? (hdr_q[4] ? 8'h00 : 8'hFF) : dx_q;
  assign y_sat   = hdr_q[7] ? (hdr_q[5] ? 8'h00 : 8'hFF) : rx_data_i;
  assign tmo_hit = (cnt_q == TIMEOUT - 16'd1);

  always_comb begin
    state_d   = state_q;
    hdr_d     = hdr_q;
    dx_d      = dx_q;
    cnt_d     = cnt_q;
    mouse_d   = mouse_q;
    pkt_err_d = 1'b0;
    if (rx_err_i) begin
      state_d   = S_HDR;
      cnt_d     = '0;
      pkt_err_d = 1'b1;
    end else begin
      case (state_q)
        S_HDR: begin
          cnt_d = '0;
          if (rx_valid_i) begin
            if (rx_data_i[3]) begin
              // bit3 is the sync marker and always reads 0 in the output word
              hdr_d   = rx_data_i & 8'hF7;
              state_d = S_DX;
            end else begin
              pkt_err_d = 1'b1;
            end
          end
        end
        S_DX: begin
          if (rx_valid_i) begin
            dx_d    = rx_data_i;
            cnt_d   = '0;
            state_d = S_DY;
          end else if (tmo_hit) begin
            cnt_d     = '0;
            state_d   = S_HDR;
            pkt_err_d = 1'b1;
          end else begin
            cnt_d = cnt_q + 16'd1;
          end
        end
        S_DY: begin
          if (rx_valid_i) begin
            mouse_d = {~mouse_q[24], y_sat, x_sat, hdr_q};
            cnt_d   = '0;
            state_d = S_HDR;
          end else if (tmo_hit) begin
            cnt_d     = '0;
            state_d   = S_HDR;
            pkt_err_d = 1'b1;
          end else begin
            cnt_d = cnt_q + 16'd1;
          end
        end
        default: begin
          state_d = S_HDR;
          cnt_d   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q   <= S_HDR;
      hdr_q     <= '0;
      dx_q      <= '0;
      cnt_q     <= '0;
      mouse_q   <= '0;
      pkt_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      hdr_q     <= hdr_d;
      dx_q      <= dx_d;
      cnt_q     <= cnt_d;
      mouse_q   <= mouse_d;
      pkt_err_q <= pkt_err_d;
    end
  end

  assign mouse_o   = mouse_q;
  assign pkt_err_o = pkt_err_q;

endmodule

// File: tb/tb_ps2_mouse_packer.sv
// Scoreboard bench for ps2_mouse_packer: expected words and error pulses are
// queued with their due cycle when stimulus is driven, and popped on DUT output.
module tb_ps2_mouse_packer;

  localparam int T = 40;

  logic        clk_i = 1'b0;
  logic        reset_i = 1'b1;
  logic [7:0]  rx_data_i = 8'h00;
  logic        rx_valid_i = 1'b0;
  logic        rx_err_i = 1'b0;
  logic [24:0] mouse_o;
  logic        pkt_err_o;

  ps2_mouse_packer #(.TIMEOUT(16'(T))) dut (
    .clk_i(clk_i), .reset_i(reset_i), .rx_data_i(rx_data_i),
    .rx_valid_i(rx_valid_i), .rx_err_i(rx_err_i),
    .mouse_o(mouse_o), .pkt_err_o(pkt_err_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct { logic [24:0] w; int due; } exp_t;
  exp_t exp_q[$];
  int   err_q[$];

  int n_checks = 0;
  int n_fail = 0;
  int cyc = 0;
  always @(posedge clk_i) cyc <= cyc + 1;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=0x%0h expected=0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Reference model state
  int          m_st = 0;
  logic [7:0]  m_hdr, m_dx;
  logic [24:0] m_mouse = '0;
  int          last_drive = 0;

  function automatic logic [24:0] pack(input logic [7:0] h, input logic [7:0] x,
                                       input logic [7:0] y, input logic tog);
    logic [7:0] xs, ys;
    xs = x;
    ys = y;
    if (h[6]) xs = h[4] ? 8'h00 : 8'hFF;
    if (h[7]) ys = h[5] ? 8'h00 : 8'hFF;
    return {tog, ys, xs, h[7], h[6], h[5], h[4], 1'b0, h[2], h[1], h[0]};
  endfunction

  task automatic drive_byte(input logic [7:0] b);
    exp_t e;
    rx_data_i  = b;
    rx_valid_i = 1'b1;
    case (m_st)
      0: if (b[3]) begin m_hdr = b; m_st = 1; end
         else err_q.push_back(cyc + 1);
      1: begin m_dx = b; m_st = 2; end
      default: begin
        m_mouse = pack(m_hdr, m_dx, b, ~m_mouse[24]);
        e.w = m_mouse;
        e.due = cyc + 1;
        exp_q.push_back(e);
        m_st = 0;
      end
    endcase
    last_drive = cyc;
    @(posedge clk_i); #1;
    rx_valid_i = 1'b0;
  endtask

  task automatic idle(input int g);
    if (m_st != 0 && g >= T) begin
      err_q.push_back(last_drive + 1 + T);
      m_st = 0;
    end
    repeat (g) begin @(posedge clk_i); #1; end
  endtask

  task automatic rx_error(input logic with_valid, input logic [7:0] b);
    rx_err_i   = 1'b1;
    rx_valid_i = with_valid;
    rx_data_i  = b;
    err_q.push_back(cyc + 1);
    m_st = 0;
    @(posedge clk_i); #1;
    rx_err_i   = 1'b0;
    rx_valid_i = 1'b0;
  endtask

  task automatic do_reset();
    reset_i = 1'b1;
    repeat (2) begin @(posedge clk_i); #1; end
    check_val("reset_mouse", mouse_o, 25'h0);
    check_val("reset_pkt_err", pkt_err_o, 1'b0);
    m_mouse = '0;
    m_st = 0;
    reset_i = 1'b0;
  endtask

  task automatic packet(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c);
    drive_byte(a);
    drive_byte(b);
    drive_byte(c);
  endtask

  logic [24:0] prev;
  always @(negedge clk_i) begin
    if (reset_i) begin
      prev = mouse_o;
    end else begin
      if (mouse_o !== prev) begin
        if (exp_q.size() == 0) check_val("mouse_unexpected", mouse_o, prev);
        else begin
          exp_t e;
          e = exp_q.pop_front();
          check_val("mouse_word", mouse_o, e.w);
          check_val("mouse_latency", cyc, e.due);
        end
        prev = mouse_o;
      end
      if (pkt_err_o !== 1'b0) begin
        if (err_q.size() == 0) check_val("pkt_err_unexpected", pkt_err_o, 1'b0);
        else check_val("pkt_err_cycle", cyc, err_q.pop_front());
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired cycle=%0d", cyc);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    do_reset();
    idle(2);

    packet(8'h29, 8'h05, 8'hFB);
    idle(2);
    check_val("t1_word", mouse_o, 25'h1FB0521);

    drive_byte(8'h01);
    idle(1);
    packet(8'h0A, 8'h00, 8'h00);
    idle(2);
    check_val("t2_buttons", mouse_o[1:0], 2'b10);

    drive_byte(8'h08); drive_byte(8'h10);
    idle(T + 2);
    packet(8'h09, 8'h01, 8'h01);
    idle(2);
    check_val("t3_dx", mouse_o[15:8], 8'h01);

    drive_byte(8'h08); drive_byte(8'h03);
    rx_error(1'b0, 8'h00);
    packet(8'h08, 8'h00, 8'h00);
    idle(2);

    packet(8'h58, 8'h7F, 8'h00);
    idle(2);
    check_val("t5_xsat_neg", mouse_o[15:8], 8'h00);
    packet(8'h48, 8'h12, 8'h00);
    idle(2);
    check_val("t5_xsat_pos", mouse_o[15:8], 8'hFF);
    packet(8'hA8, 8'h01, 8'h33);
    packet(8'h88, 8'h02, 8'h44);
    idle(2);

    // Error with simultaneous valid in DY: byte must be discarded
    drive_byte(8'h08); drive_byte(8'h01);
    rx_error(1'b1, 8'h55);
    rx_error(1'b0, 8'h00);
    packet(8'h0C, 8'h11, 8'h22);
    idle(2);

    // Gap of T-1 idle cycles: byte lands on the terminal count and wins
    drive_byte(8'h08); drive_byte(8'h20);
    idle(T - 1);
    drive_byte(8'h33);
    drive_byte(8'h09);
    idle(T - 1);
    drive_byte(8'h44);
    idle(T - 1);
    drive_byte(8'h55);
    idle(2);
    // Gap of exactly T: timeout fires, then the late byte is a bad header
    drive_byte(8'h08);
    idle(T);
    drive_byte(8'h10);
    idle(2);

    drive_byte(8'h08); drive_byte(8'h05);
    do_reset();
    idle(1);
    packet(8'h08, 8'h01, 8'h02);
    idle(2);
    check_val("t6_toggle", mouse_o[24], 1'b1);

    for (int i = 0; i < 40; i++) begin
      logic [7:0] h;
      h = 8'($urandom_range(0, 255));
      if ($urandom_range(0, 5) != 0) h[3] = 1'b1;
      drive_byte(h);
      idle($urandom_range(0, 7) == 0 ? T : $urandom_range(0, 3));
      drive_byte(8'($urandom_range(0, 255)));
      if ($urandom_range(0, 9) == 0) rx_error(1'($urandom_range(0, 1)), 8'hAA);
      drive_byte(8'($urandom_range(0, 255)));
      idle($urandom_range(0, 2));
    end
    idle(T + 4);

    check_val("sb_mouse_empty", exp_q.size(), 0);
    check_val("sb_err_empty", err_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
